// File: rtl/neuron_sequencer_if.sv
// APB bus bundle for the neuron sequencer.
// Carries the APB control (PSEL/PENABLE/PWRITE), address, write data, read data,
// ready and slave error. "master" is the bus initiator, "slave" the sequencer.
interface neuron_sequencer_if #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 12
) ();

  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/neuron_sequencer.sv
// Neuron sequencer: APB slave that owns the pixel memory, weight memory and neuron
// calculator. While idle it forwards pixel writes into pixel memory and holds the
// bias. A start command clears the calculator, streams every pixel address through
// both memories, requests the result and latches the cat/not-cat bit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   apb                 APB slave (zero wait, PREADY tied high)
//   mem_we/mem_wdata    pixel memory write strobe and data
//   mem_re              pixel/weight memory read strobe
//   mem_addr            shared memory address
//   calc_clear          one-cycle accumulator clear
//   calc_enable         accumulate this cycle (read strobe delayed by memory latency)
//   calc_get_result     one-cycle result request
//   calc_bias           bias register to calculator
//   calc_result         calculator output bit
//   irq                 level interrupt: done & irq_en
module neuron_sequencer #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 12,
  parameter int unsigned Num_Pixels      = 3072,
  parameter int unsigned Drain_Cycles    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  neuron_sequencer_if.slave          apb,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  output logic [Amba_Word-1:0]       mem_wdata,
  output logic                       calc_clear,
  output logic                       calc_enable,
  output logic                       calc_get_result,
  output logic [Amba_Word-1:0]       calc_bias,
  input  logic                       calc_result,
  output logic                       irq
);

  localparam int unsigned AW = Amba_Addr_Depth;
  localparam int unsigned W  = Amba_Word;

  localparam logic [AW-1:0] CtrlAddr  = '1;
  localparam logic [AW-1:0] BiasAddr  = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0] PixCount  = AW'(Num_Pixels);
  localparam logic [AW-1:0] LastPix   = AW'(Num_Pixels - 1);
  localparam logic [AW-1:0] DrainLast = AW'(Drain_Cycles);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StResult,
    StCapture,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;     // pixel index in RUN, drain count in DRAIN
  logic          en_q;
  logic [W-1:0]  bias_q;
  logic          irq_en_q;
  logic          result_q;

  logic access, busy, done;
  logic is_pix, is_ctrl, is_bias;
  logic ctrl_wr, bias_wr, pix_wr;

  // APB decode
  assign access  = apb.PSEL & apb.PENABLE;
  assign is_pix  = apb.PADDR < PixCount;
  assign is_ctrl = apb.PADDR == CtrlAddr;
  assign is_bias = apb.PADDR == BiasAddr;
  assign busy    = (state_q != StIdle) && (state_q != StDone);
  assign done    = state_q == StDone;

  assign ctrl_wr = access & apb.PWRITE & is_ctrl;
  assign bias_wr = access & apb.PWRITE & is_bias & ~busy;
  assign pix_wr  = access & apb.PWRITE & is_pix & ~busy;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (~(is_pix | is_ctrl | is_bias) |
                                 (apb.PWRITE & busy & (is_pix | is_bias)));

  always_comb begin
    apb.PRDATA = '0;
    if (access && !apb.PWRITE) begin
      if (is_ctrl) begin
        apb.PRDATA[3:0] = {irq_en_q, busy, done, result_q};
      end else if (is_bias) begin
        apb.PRDATA = bias_q;
      end
    end
  end

  // Sequencer FSM
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    calc_clear      = 1'b0;
    mem_re          = 1'b0;
    calc_get_result = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        // start wins over clear_done when both are set
        if (ctrl_wr && apb.PWDATA[0]) begin
          state_d = StClear;
        end else if (state_q == StDone && ctrl_wr && apb.PWDATA[2]) begin
          state_d = StIdle;
        end
      end
      StClear: begin
        calc_clear = 1'b1;
        cnt_d      = '0;
        state_d    = StRun;
      end
      StRun: begin
        mem_re = 1'b1;
        if (cnt_q == LastPix) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // 1 + Drain_Cycles cycles: the last calc_enable lands in the first one
        if (cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StResult;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResult: begin
        calc_get_result = 1'b1;
        state_d         = StCapture;
      end
      StCapture: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      bias_q   <= '0;
      irq_en_q <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= mem_re;   // memory read data arrives one cycle after the strobe
      if (bias_wr) bias_q <= apb.PWDATA;
      if (ctrl_wr) irq_en_q <= apb.PWDATA[1];
      if (state_q == StCapture) result_q <= calc_result;
    end
  end

  assign mem_we      = pix_wr;
  assign mem_addr    = mem_re ? cnt_q : (pix_wr ? apb.PADDR : '0);
  assign mem_wdata   = pix_wr ? apb.PWDATA : '0;
  assign calc_enable = en_q;
  assign calc_bias   = bias_q;
  assign irq         = done & irq_en_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
module tb_neuron_sequencer;

  localparam int unsigned W  = 24;
  localparam int unsigned AW = 12;
  localparam int          N  = 4;
  localparam int          D  = 2;
  localparam int          Last = N + D + 4;  // CAPTURE cycle index after the start edge
  localparam logic [AW-1:0] CTRL = 12'hFFF;
  localparam logic [AW-1:0] BIAS = 12'hFFE;

  logic          clk;
  logic          rst;
  logic          mem_we, mem_re, calc_clear, calc_enable, calc_get_result, irq;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, calc_bias;
  logic          calc_result;

  int n_checks = 0;
  int n_pass   = 0;

  neuron_sequencer_if #(.Amba_Word(W), .Amba_Addr_Depth(AW)) bus ();

  neuron_sequencer #(
    .Amba_Word(W),
    .Amba_Addr_Depth(AW),
    .Num_Pixels(N),
    .Drain_Cycles(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .apb(bus.slave),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .calc_clear(calc_clear),
    .calc_enable(calc_enable),
    .calc_get_result(calc_get_result),
    .calc_bias(calc_bias),
    .calc_result(calc_result),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: t counts cycles since an accepted start (1 = CLEAR cycle), 0 = not running
  int           t;
  logic         done_m, result_m, irq_en_m;
  logic [W-1:0] bias_m;
  logic         busy_m, acc, wr_ctrl, wr_bias;

  assign busy_m  = (t != 0);
  assign acc     = bus.PSEL & bus.PENABLE;
  assign wr_ctrl = acc & bus.PWRITE & (bus.PADDR == CTRL);
  assign wr_bias = acc & bus.PWRITE & (bus.PADDR == BIAS);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t        <= 0;
      done_m   <= 1'b0;
      result_m <= 1'b0;
      irq_en_m <= 1'b0;
      bias_m   <= '0;
    end else begin
      if (busy_m) begin
        if (t == Last) begin
          t        <= 0;
          done_m   <= 1'b1;
          result_m <= calc_result;
        end else begin
          t <= t + 1;
        end
      end
      if (wr_ctrl) begin
        irq_en_m <= bus.PWDATA[1];
        if (!busy_m && bus.PWDATA[0]) begin
          t      <= 1;
          done_m <= 1'b0;
        end else if (!busy_m && bus.PWDATA[2]) begin
          done_m <= 1'b0;
        end
      end
      if (wr_bias && !busy_m) bias_m <= bus.PWDATA;
    end
  end

  always @(negedge clk) begin : mon
    logic         pix, legal, we, re;
    logic [AW-1:0] ea;
    logic [W-1:0] ep;
    pix   = bus.PADDR < AW'(N);
    legal = pix | (bus.PADDR == CTRL) | (bus.PADDR == BIAS);
    we    = acc & bus.PWRITE & pix & ~busy_m;
    re    = (t >= 2) && (t <= N + 1);
    ea    = re ? AW'(t - 2) : (we ? bus.PADDR : '0);
    ep    = '0;
    if (acc && !bus.PWRITE) begin
      if (bus.PADDR == CTRL) ep[3:0] = {irq_en_m, busy_m, done_m, result_m};
      else if (bus.PADDR == BIAS) ep = bias_m;
    end
    chk("calc_clear", calc_clear, t == 1);
    chk("mem_re", mem_re, re);
    chk("calc_enable", calc_enable, (t >= 3) && (t <= N + 2));
    chk("calc_get_result", calc_get_result, t == N + D + 3);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, we ? bus.PWDATA : '0);
    chk("pslverr", bus.PSLVERR,
        acc & (~legal | (bus.PWRITE & busy_m & (pix | (bus.PADDR == BIAS)))));
    chk("prdata", bus.PRDATA, ep);
    chk("calc_bias", calc_bias, bias_m);
    chk("irq", irq, done_m & irq_en_m);
    chk("pready", bus.PREADY, 1'b1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 calc_result = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the access-phase edge.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    @(posedge clk);
    #1 bus.PENABLE = 1'b1;
    @(posedge clk);
    #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    calc_result = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_clear", calc_clear, 0);
    chk("rst_enable", calc_enable, 0);
    chk("rst_get", calc_get_result, 0);
    chk("rst_irq", irq, 0);
    apb_xfer(1'b0, CTRL, '0);
    apb_xfer(1'b0, BIAS, '0);

    // Pixel write in idle
    apb_xfer(1'b1, 12'd5, 24'h00ABCD);
    apb_xfer(1'b1, BIAS, 24'h000123);

    // Run with irq enabled, mid-run pixel/bias writes and a second start
    apb_xfer(1'b1, CTRL, 24'h3);          // now in cycle 1
    idle(2);                              // cycle 3
    apb_xfer(1'b1, 12'd1, 24'h111111);    // access in cycle 4
    apb_xfer(1'b1, BIAS, 24'h0F0F0F);     // access in cycle 6
    apb_xfer(1'b1, CTRL, 24'h3);          // access in cycle 8, ignored as a start
    idle(Last - 9);                       // cycle Last
    chk("irq_before_done", irq, 0);
    idle(1);
    chk("irq_at_done", irq, 1);
    apb_xfer(1'b0, CTRL, '0);
    apb_xfer(1'b1, CTRL, 24'h6);          // clear_done, keep irq_en
    chk("irq_after_clear", irq, 0);
    apb_xfer(1'b1, 12'd3000, 24'h1);
    apb_xfer(1'b0, 12'd3000, '0);

    // Reset mid-run at k=2
    apb_xfer(1'b1, CTRL, 24'h1);          // cycle 1
    idle(3);                              // cycle 4: address 2 issued
    chk("run_addr_k2", mem_addr, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_mem_re", mem_re, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_enable", calc_enable, 0);
    chk("async_clear", calc_clear, 0);
    idle(2);
    rst = 1'b0;
    apb_xfer(1'b0, CTRL, '0);
    apb_xfer(1'b0, BIAS, '0);
    apb_xfer(1'b1, CTRL, 24'h1);
    idle(Last + 1);
    apb_xfer(1'b0, CTRL, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int          kind;
      logic [AW-1:0] a;
      kind = int'($urandom_range(0, 9));
      if (kind < 4) a = AW'($urandom_range(0, N - 1));
      else if (kind < 6) a = CTRL;
      else if (kind < 8) a = BIAS;
      else a = AW'($urandom_range(N, 4093));
      apb_xfer(1'($urandom_range(0, 1)), a, W'($urandom));
      idle(int'($urandom_range(0, 4)));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- APB-slave controller that owns the shared pixel register file, the weight memory and the neuron calculator.
- Idle: routes APB writes into pixel memory and holds a bias register.
- On a software start command: clears the calculator, streams every pixel address through both memories into the calculator, requests the result, latches the cat/not-cat bit and raises done.
- The datapath stays free of APB timing.

Parameters:
- Amba_Word, 24, APB data width and pixel/bias width.
- Amba_Addr_Depth, 12, APB address width and memory address width.
- Num_Pixels, 3072, pixels per image; legal range 1..2^Amba_Addr_Depth-2.
- Drain_Cycles, 2, cycles from last calc_enable to calc_get_result (calculator pipeline depth).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write.
- PADDR  in  Amba_Addr_Depth  APB address.
- PWDATA  in  Amba_Word  APB write data.
- PRDATA  out  Amba_Word  APB read data.
- PREADY  out  1  always 1 (zero wait).
- PSLVERR  out  1  error on the access phase.
- mem_we  out  1  pixel memory write strobe.
- mem_re  out  1  pixel/weight memory read strobe.
- mem_addr  out  Amba_Addr_Depth  shared memory address.
- mem_wdata  out  Amba_Word  pixel write data.
- calc_clear  out  1  one-cycle accumulator clear.
- calc_enable  out  1  accumulate x*w this cycle.
- calc_get_result  out  1  one-cycle result request.
- calc_bias  out  Amba_Word  bias to calculator.
- calc_result  in  1  calculator output bit.
- irq  out  1  level, high while done=1 and irq_en=1.

Behaviour:
- Reset (async, rst=1): state IDLE; all strobes 0; mem_addr 0; mem_wdata 0; bias 0; done 0; result 0; irq_en 0; PRDATA 0; PSLVERR 0.
- Register map:
  - 0..Num_Pixels-1: pixel region, write-only, reads return 0.
  - CTRL = 2^Amba_Addr_Depth-1: write bit0=start, bit1=irq_en, bit2=clear_done; read = {.., irq_en[3], busy[2], done[1], result[0]}.
  - BIAS = 2^Amba_Addr_Depth-2: read/write.
  - Other addresses: read 0, write ignored, PSLVERR=1.
- APB access completes on PSEL&PENABLE. Registered effects apply on that edge. PRDATA is combinational during the access phase.
- Pixel write in IDLE/DONE: mem_we=1, mem_addr=PADDR, mem_wdata=PWDATA for exactly the access-phase cycle.
- Pixel or BIAS write while busy: dropped, PSLVERR=1. CTRL writes are always accepted.
- FSM:
  - IDLE: on start=1 go to CLEAR. done is cleared.
  - CLEAR: calc_clear=1 for 1 cycle; counter k=0; then RUN.
  - RUN: mem_re=1, mem_addr=k, k++.
    - calc_enable is mem_re delayed 1 cycle (1-cycle memory read latency).
    - After k=Num_Pixels-1 is issued, go to DRAIN.
  - DRAIN: hold for 1+Drain_Cycles cycles; the final calc_enable falls in the first of these. Then RESULT.
  - RESULT: calc_get_result=1 for 1 cycle. Go to CAPTURE.
  - CAPTURE: result<=calc_result, done<=1; then DONE.
  - DONE: start re-runs (go to CLEAR); clear_done=1 clears done and goes to IDLE.
- busy = state not in {IDLE, DONE}.
- Start written while busy: ignored, no error, and the run continues.
- Start + clear_done in the same write: start wins.
- Counter width is Amba_Addr_Depth; k never wraps because Num_Pixels ≤ 2^Amba_Addr_Depth-2.
- Total latency from start edge to done=1: 1 (CLEAR) + Num_Pixels + 1 + Drain_Cycles + 1 + 1 cycles.
- rst mid-run: immediate return to reset values. The calculator is re-cleared by the next CLEAR.
- calc_bias = bias register, stable throughout a run.

Test Plan:
- After reset: read CTRL -> 0x000000; read BIAS -> 0; irq=0; all strobes 0.
- Write pixel addr 5 data 0x00ABCD -> mem_we pulses one cycle with mem_addr=5 and mem_wdata=0x00ABCD; PSLVERR=0.
- Num_Pixels=4, Drain_Cycles=2, write start:
  - calc_clear at cycle 1.
  - mem_re for cycles 2-5 with addr 0,1,2,3.
  - calc_enable for cycles 3-6.
  - calc_get_result at cycle 9.
  - done at cycle 10 with result=calc_result sampled at cycle 10.
  - CTRL read -> 0x2|result.
- During the run, write pixel addr 1 and write BIAS -> no mem_we, PSLVERR=1, BIAS unchanged; a second start has no effect on the sequence.
- Set irq_en, run to done -> irq=1; write clear_done -> irq=0 and done=0 next cycle; write to addr 3000 with Num_Pixels=4 -> PSLVERR=1.
- Assert rst during RUN at k=2 -> all outputs return to reset values asynchronously; a fresh start then completes a normal run.
